// File: rtl/tank_input_scheduler.sv
// Per-frame keyboard scan, movement decode and fire arbitration for two tanks.
// Optional feature: define TANK_AUTOFIRE_EN for level-triggered (held-key) fire.
module tank_input_scheduler #(
    parameter int unsigned COOLDOWN  = 16,
    parameter int unsigned MAX_SHOTS = 5
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic [31:0] keycode,
    input  logic [1:0]  shot_done,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic        spawn_player,
    output logic        move1,
    output logic        move2,
    output logic [1:0]  dir1,
    output logic [1:0]  dir2,
    output logic [2:0]  live1,
    output logic [2:0]  live2
);

    localparam logic [3:0] COOL_LOAD = (COOLDOWN > 15) ? 4'd15 : 4'(COOLDOWN);
    localparam logic [2:0] SHOT_MAX  = 3'(MAX_SHOTS);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DECIDE, S_OFFER} state_t;

    state_t          r_state;
    logic [31:0]     r_scan;
    logic [9:0]      r_hit;
    logic [1:0]      r_slot;
    logic [1:0][3:0] r_cool;
    logic [1:0][2:0] r_live;
    logic [1:0]      r_move;
    logic [1:0][1:0] r_dir;
    logic            r_last_grant;
    logic            r_spawn_valid;
    logic            r_spawn_player;
`ifndef TANK_AUTOFIRE_EN
    logic [1:0]      r_fire_prev;
`endif

    logic [7:0] w_slot_key;
    logic [9:0] w_slot_hits;
    logic [1:0] w_fire;
    logic [1:0] w_req;
    logic       w_winner;
    logic       w_accept;
    logic [1:0] w_inc;

    // Hit bits: [3:0] P1 left/right/down/up, [4] P1 fire, [8:5] P2 dirs, [9] P2 fire.
    function automatic logic [9:0] key_hits(input logic [7:0] k);
        case (k)
            8'h04:   key_hits = 10'h001;
            8'h07:   key_hits = 10'h002;
            8'h16:   key_hits = 10'h004;
            8'h1A:   key_hits = 10'h008;
            8'h2C:   key_hits = 10'h010;
            8'h50:   key_hits = 10'h020;
            8'h4F:   key_hits = 10'h040;
            8'h51:   key_hits = 10'h080;
            8'h52:   key_hits = 10'h100;
            8'h28:   key_hits = 10'h200;
            default: key_hits = 10'h000;
        endcase
    endfunction

    function automatic logic [1:0] pick_dir(input logic [3:0] h, input logic [1:0] held);
        if (h[0])      pick_dir = 2'b00;
        else if (h[1]) pick_dir = 2'b01;
        else if (h[2]) pick_dir = 2'b10;
        else if (h[3]) pick_dir = 2'b11;
        else           pick_dir = held;
    endfunction

    always_comb begin
        w_slot_key  = r_scan[{r_slot, 3'b000} +: 8];
        w_slot_hits = key_hits(w_slot_key);
`ifdef TANK_AUTOFIRE_EN
        w_fire = {r_hit[9], r_hit[4]};
`else
        w_fire = {r_hit[9], r_hit[4]} & ~r_fire_prev;
`endif
        for (int p = 0; p < 2; p++) begin
            w_req[p] = w_fire[p] && (r_cool[p] == 4'd0) && (r_live[p] < SHOT_MAX);
        end
        case (w_req)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = ~r_last_grant;
            default: w_winner = 1'b0;
        endcase
        w_accept = (r_state == S_OFFER) && spawn_ready;
        for (int p = 0; p < 2; p++) begin
            w_inc[p] = w_accept && (r_spawn_player == 1'(p));
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state        <= S_IDLE;
            r_scan         <= '0;
            r_hit          <= '0;
            r_slot         <= '0;
            r_cool         <= '0;
            r_live         <= '0;
            r_move         <= '0;
            r_dir          <= '0;
            r_last_grant   <= 1'b1;
            r_spawn_valid  <= 1'b0;
            r_spawn_player <= 1'b0;
`ifndef TANK_AUTOFIRE_EN
            r_fire_prev    <= '0;
`endif
        end else begin
            // Per-player bookkeeping runs regardless of FSM state; accept load beats tick decrement.
            for (int p = 0; p < 2; p++) begin
                if (w_inc[p])
                    r_cool[p] <= COOL_LOAD;
                else if (frame_tick && (r_cool[p] != 4'd0))
                    r_cool[p] <= r_cool[p] - 4'd1;

                if (w_inc[p] && !shot_done[p] && (r_live[p] < SHOT_MAX))
                    r_live[p] <= r_live[p] + 3'd1;
                else if (!w_inc[p] && shot_done[p] && (r_live[p] != 3'd0))
                    r_live[p] <= r_live[p] - 3'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_scan  <= keycode;
                        r_hit   <= '0;
                        r_slot  <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_hit  <= r_hit | w_slot_hits;
                    r_slot <= r_slot + 2'd1;
                    if (r_slot == 2'd3) r_state <= S_DECIDE;
                end
                S_DECIDE: begin
                    r_move[0] <= |r_hit[3:0];
                    r_move[1] <= |r_hit[8:5];
                    r_dir[0]  <= pick_dir(r_hit[3:0], r_dir[0]);
                    r_dir[1]  <= pick_dir(r_hit[8:5], r_dir[1]);
`ifndef TANK_AUTOFIRE_EN
                    r_fire_prev <= {r_hit[9], r_hit[4]};
`endif
                    if (|w_req) begin
                        r_spawn_valid  <= 1'b1;
                        r_spawn_player <= w_winner;
                        r_state        <= S_OFFER;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_OFFER: begin
                    if (spawn_ready) begin
                        r_spawn_valid <= 1'b0;
                        r_last_grant  <= r_spawn_player;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign spawn_valid  = r_spawn_valid;
    assign spawn_player = r_spawn_player;
    assign move1        = r_move[0];
    assign move2        = r_move[1];
    assign dir1         = r_dir[0];
    assign dir2         = r_dir[1];
    assign live1        = r_live[0];
    assign live2        = r_live[1];

endmodule
